// File: rtl/reg_update_arbiter.sv
// reg_update_arbiter: round-robin arbiter in front of a shared counter register.
// Each cycle at most one requester wins; its inc/dec/load/clear op is applied to
// count at the same edge, and a registered response reports the new value.
// Optional feature macro: SATURATE_EN (inc/dec clamp at the range limits and
// pulse sat_flag). Without it, arithmetic wraps and sat_flag is tied low.
module reg_update_arbiter #(
  parameter int               NREQ  = 4,
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    resp_valid,
  output logic [2:0]              resp_id,
  output logic [WIDTH-1:0]        resp_value,
  output logic [WIDTH-1:0]        count,
  output logic                    sat_flag
);

  localparam logic [1:0] OP_INC   = 2'b00;
  localparam logic [1:0] OP_DEC   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [2:0]       ptr;
  logic [2:0]       ptr_next;
  logic [2:0]       gnt_idx;
  logic             gnt_any;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] count_next;
`ifdef SATURATE_EN
  logic             clamp;
`endif

  // Round-robin pick: first valid at or above ptr, otherwise the lowest valid
  // index below ptr (the wrap-around part of the scan).
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 3'd0;
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_any && req_valid[j] && (3'(j) >= ptr)) begin
        gnt_any = 1'b1;
        gnt_idx = 3'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = 3'(j);
      end
    end
  end

  assign accept   = gnt_any && !reset;
  assign ptr_next = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;

  // Grant vector and winner's op/data mux; grant is suppressed during reset.
  always_comb begin
    req_ready = '0;
    sel_op    = OP_INC;
    sel_data  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_idx == 3'(j)) begin
        req_ready[j] = accept;
        sel_op       = req_op[2*j +: 2];
        sel_data     = req_data[WIDTH*j +: WIDTH];
      end
    end
  end

  // Value the counter takes if the winner's op is applied this cycle.
  always_comb begin
    count_next = count;
`ifdef SATURATE_EN
    clamp = 1'b0;
`endif
    case (sel_op)
      OP_INC: begin
`ifdef SATURATE_EN
        if (&count) clamp = 1'b1;
        else        count_next = count + WIDTH'(1);
`else
        count_next = count + WIDTH'(1);
`endif
      end
      OP_DEC: begin
`ifdef SATURATE_EN
        if (count == '0) clamp = 1'b1;
        else             count_next = count - WIDTH'(1);
`else
        count_next = count - WIDTH'(1);
`endif
      end
      OP_LOAD:  count_next = sel_data;
      OP_CLEAR: count_next = '0;
      default:  count_next = count;
    endcase
  end

  // Counter, priority pointer and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= INIT;
      ptr        <= 3'd0;
      resp_valid <= 1'b0;
      resp_id    <= 3'd0;
      resp_value <= INIT;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        count      <= count_next;
        ptr        <= ptr_next;
        resp_id    <= gnt_idx;
        resp_value <= count_next;
      end
    end
  end

`ifdef SATURATE_EN
  // Clamp indicator, aligned with resp_valid of the clamped op.
  always_ff @(posedge clk) begin
    if (reset) sat_flag <= 1'b0;
    else       sat_flag <= accept && clamp;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_reg_update_arbiter.sv
// Self-checking bench for reg_update_arbiter (NREQ=4, WIDTH=8, INIT=5).
// A reference model predicts grants and counter values; expected responses are
// queued when a request is driven and popped when the DUT raises resp_valid.
module tb_reg_update_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam logic [7:0] INIT = 8'd5;
`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [2:0]  resp_id;
  logic [7:0]  resp_value;
  logic [7:0]  count;
  logic        sat_flag;

  reg_update_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .INIT(INIT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_data(req_data), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_value(resp_value), .count(count), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] id;
    logic [7:0] value;
    logic       sat;
  } resp_t;

  resp_t      exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         m_ptr;
  logic [7:0] m_count;
  logic [3:0] exp_ready;
  logic [3:0] obs_ready;
  logic       exp_rv;
  int         last_grant;

  // Samples req_ready before the edge, advances the model, then clocks once.
  task automatic step();
    int g;
    logic [1:0] op;
    logic [7:0] nv;
    logic s;
    #1;
    obs_ready = req_ready;
    g = -1;
    if (!reset) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    exp_ready  = '0;
    exp_rv     = 1'b0;
    last_grant = g;
    if (reset) begin
      m_count = INIT;
      m_ptr   = 0;
      exp_q.delete();
    end else if (g >= 0) begin
      exp_ready[g] = 1'b1;
      op = req_op[2*g +: 2];
      nv = m_count;
      s  = 1'b0;
      case (op)
        2'b00: if (SAT && m_count == 8'hFF) s = 1'b1; else nv = m_count + 8'd1;
        2'b01: if (SAT && m_count == 8'h00) s = 1'b1; else nv = m_count - 8'd1;
        2'b10: nv = req_data[8*g +: 8];
        default: nv = 8'h00;
      endcase
      m_count = nv;
      m_ptr   = (g + 1) % NREQ;
      exp_q.push_back('{3'(g), nv, s});
      exp_rv = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'hF; req_op = 8'h00; req_data = 32'h0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin reset = 1'b0; req_valid = 4'h0; end
      step();
      checks++;
      if (obs_ready !== 4'h0) begin errors++; $display("FAIL reset_ready c=%0d got=%b exp=0000", c, obs_ready); end
      checks++;
      if (count !== INIT) begin errors++; $display("FAIL reset_count c=%0d got=%0d exp=%0d", c, count, INIT); end
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_rv c=%0d got=%b exp=0", c, resp_valid); end
    end
    checks++;
    if (resp_id !== 3'd0 || resp_value !== INIT || sat_flag !== 1'b0) begin
      errors++; $display("FAIL reset_resp got id=%0d val=%0d sat=%b exp id=0 val=%0d sat=0", resp_id, resp_value, sat_flag, INIT);
    end
  endtask

  task automatic test_single_requester();
    resp_t e;
    req_valid = 4'b0100; req_op = 8'h00;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (obs_ready !== 4'b0100) begin errors++; $display("FAIL single_ready c=%0d got=%b exp=0100", c, obs_ready); end
      checks++;
      if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_rv c=%0d got=%b exp=1", c, resp_valid); end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (resp_id !== 3'd2 || resp_value !== e.value || resp_value !== 8'(6 + c)) begin
          errors++; $display("FAIL single_resp c=%0d got id=%0d val=%0d exp id=2 val=%0d", c, resp_id, resp_value, 6 + c);
        end
      end
      checks++;
      if (count !== 8'(6 + c)) begin errors++; $display("FAIL single_count c=%0d got=%0d exp=%0d", c, count, 6 + c); end
    end
    req_valid = 4'h0;
  endtask

  task automatic test_round_robin();
    resp_t e;
    logic [7:0] c0;
    req_valid = 4'b1000; req_op = 8'h00;
    step();
    exp_q.delete();
    c0 = m_count;
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (obs_ready !== 4'(1 << (c % 4)) || obs_ready !== exp_ready) begin
        errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, obs_ready, 4'(1 << (c % 4)));
      end
      if (resp_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (resp_id !== e.id || resp_value !== e.value) begin
          errors++; $display("FAIL rr_resp c=%0d got id=%0d val=%0d exp id=%0d val=%0d", c, resp_id, resp_value, e.id, e.value);
        end
      end else begin
        checks++; errors++; $display("FAIL rr_rv c=%0d got=%b exp=1", c, resp_valid);
      end
    end
    checks++;
    if (count !== c0 + 8'd8) begin errors++; $display("FAIL rr_count got=%0d exp=%0d", count, c0 + 8'd8); end
    req_valid = 4'h0;
  endtask

  task automatic test_wrap();
    resp_t e;
    logic [1:0] ops [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
    logic [7:0] want_cnt [4];
    logic       want_sat [4];
    want_cnt = SAT ? '{8'hFF, 8'hFF, 8'h00, 8'h00} : '{8'hFF, 8'h00, 8'h00, 8'hFF};
    want_sat = SAT ? '{1'b0, 1'b1, 1'b0, 1'b1} : '{1'b0, 1'b0, 1'b0, 1'b0};
    req_valid = 4'b0001; req_data = 32'h000000FF;
    for (int c = 0; c < 4; c++) begin
      req_op = {6'b0, ops[c]};
      step();
      checks++;
      if (count !== want_cnt[c] || count !== m_count) begin
        errors++; $display("FAIL wrap_count c=%0d got=%h exp=%h", c, count, want_cnt[c]);
      end
      if (resp_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sat_flag !== want_sat[c] || sat_flag !== e.sat || resp_value !== e.value) begin
          errors++; $display("FAIL wrap_resp c=%0d got sat=%b val=%h exp sat=%b val=%h", c, sat_flag, resp_value, want_sat[c], e.value);
        end
      end else begin
        checks++; errors++; $display("FAIL wrap_rv c=%0d got=%b exp=1", c, resp_valid);
      end
    end
    req_valid = 4'h0;
  endtask

  task automatic test_load_clear_priority();
    req_valid = 4'b0010; req_op = 8'h00;
    step();
    exp_q.delete();
    req_valid = 4'b1010; req_op = 8'b11_00_10_00; req_data = 32'h0000A500;
    step();
    checks++;
    if (obs_ready !== 4'b1000) begin errors++; $display("FAIL prio_first got=%b exp=1000", obs_ready); end
    checks++;
    if (count !== 8'h00 || resp_id !== 3'd3) begin errors++; $display("FAIL prio_clear got cnt=%h id=%0d exp cnt=00 id=3", count, resp_id); end
    req_valid = 4'b0010;
    step();
    checks++;
    if (obs_ready !== 4'b0010) begin errors++; $display("FAIL prio_second got=%b exp=0010", obs_ready); end
    checks++;
    if (count !== 8'hA5 || resp_id !== 3'd1 || resp_value !== 8'hA5) begin
      errors++; $display("FAIL prio_load got cnt=%h id=%0d val=%h exp cnt=a5 id=1 val=a5", count, resp_id, resp_value);
    end
    exp_q.delete();
    req_valid = 4'h0;
  endtask

  task automatic test_reset_midstream();
    req_valid = 4'b0001; req_op = 8'h00;
    step();
    reset = 1'b1;
    step();
    checks++;
    if (obs_ready !== 4'h0) begin errors++; $display("FAIL midrst_ready got=%b exp=0000", obs_ready); end
    checks++;
    if (count !== INIT || resp_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state got cnt=%0d rv=%b exp cnt=%0d rv=0", count, resp_valid, INIT);
    end
    reset = 1'b0; req_valid = 4'h0;
    step();
    checks++;
    if (resp_valid !== 1'b0 || count !== INIT) begin
      errors++; $display("FAIL midrst_after got cnt=%0d rv=%b exp cnt=%0d rv=0", count, resp_valid, INIT);
    end
  endtask

  task automatic test_back_to_back();
    resp_t e;
    req_valid = 4'h0;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
          req_valid[i]       = 1'b1;
          req_op[2*i +: 2]   = 2'($urandom_range(0, 3));
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
      step();
      checks++;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, obs_ready, exp_ready); end
      checks++;
      if (resp_valid !== exp_rv) begin errors++; $display("FAIL b2b_rv c=%0d got=%b exp=%b", c, resp_valid, exp_rv); end
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_unexpected c=%0d id=%0d", c, resp_id);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (resp_id !== e.id || resp_value !== e.value || sat_flag !== e.sat) begin
            errors++; $display("FAIL b2b_resp c=%0d got id=%0d val=%h sat=%b exp id=%0d val=%h sat=%b",
                               c, resp_id, resp_value, sat_flag, e.id, e.value, e.sat);
          end
        end
      end
      checks++;
      if (count !== m_count) begin errors++; $display("FAIL b2b_count c=%0d got=%h exp=%h", c, count, m_count); end
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
    end
    req_valid = 4'h0;
  endtask

  initial begin
    m_ptr = 0; m_count = INIT;
    test_reset();
    test_single_requester();
    test_round_robin();
    test_wrap();
    test_load_clear_priority();
    test_reset_midstream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
